// File: rtl/fifo_read_checker.sv
// fifo_read_checker
//   Read-domain consumer for the async FIFO test harness. After an accepted
//   start it drains num_words words through the FIFO read port. An optional
//   throttle inserts idle cycles after each read. Every word is checked
//   against an incrementing expected sequence that begins at seed.
//
// Ports
//   read_clk / read_rst        : clock, asynchronous active-high reset
//   start, num_words, seed,
//   throttle                   : run request and its parameters (latched
//                                only when the run is accepted in IDLE)
//   p_read_empty / p_read_en   : FIFO empty flag / read request
//   read_data                  : FIFO data, valid the cycle after a read
//   busy, done, error          : run status (error is sticky per run)
//   error_count, word_count    : per-run counters (error_count saturates)
//   first_err_index/_data/
//   _expected                  : capture of the first mismatch in the run
module fifo_read_checker #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   read_clk,
  input  logic                   read_rst,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_words,
  input  logic [DATA_WIDTH-1:0]  seed,
  input  logic [3:0]             throttle,
  input  logic                   p_read_empty,
  output logic                   p_read_en,
  input  logic [DATA_WIDTH-1:0]  read_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic [COUNT_WIDTH-1:0] first_err_index,
  output logic [DATA_WIDTH-1:0]  first_err_data,
  output logic [DATA_WIDTH-1:0]  first_err_expected
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] num_q, num_d;
  logic [DATA_WIDTH-1:0]  exp_q, exp_d;
  logic [3:0]             thr_q, thr_d;
  logic [COUNT_WIDTH-1:0] issued_q, issued_d;
  logic [3:0]             gap_q, gap_d;
  logic                   vld_q, vld_d;
  logic [COUNT_WIDTH-1:0] word_q, word_d;
  logic [COUNT_WIDTH-1:0] errc_q, errc_d;
  logic                   error_q, error_d;
  logic [COUNT_WIDTH-1:0] fe_idx_q, fe_idx_d;
  logic [DATA_WIDTH-1:0]  fe_data_q, fe_data_d;
  logic [DATA_WIDTH-1:0]  fe_exp_q, fe_exp_d;

  logic start_acc;
  logic accept;

  assign start_acc = (state_q == S_IDLE) && start;
  assign accept    = p_read_en;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge read_clk or posedge read_rst) begin
    if (read_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // The drain exit looks at the next-cycle word count, so DONE is entered
  // on the same edge that performs the final compare.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_words == '0) ? S_DONE : S_RUN;
      S_RUN:   if (issued_d == num_q) state_d = S_DRAIN;
      S_DRAIN: if (word_d == num_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    p_read_en = (state_q == S_RUN) && !p_read_empty && (gap_q == 4'd0) &&
                (issued_q < num_q);
    busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    done      = (state_q == S_DONE);
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    num_d     = num_q;
    exp_d     = exp_q;
    thr_d     = thr_q;
    issued_d  = issued_q;
    gap_d     = gap_q;
    vld_d     = 1'b0;
    word_d    = word_q;
    errc_d    = errc_q;
    error_d   = error_q;
    fe_idx_d  = fe_idx_q;
    fe_data_d = fe_data_q;
    fe_exp_d  = fe_exp_q;

    if (start_acc) begin
      num_d     = num_words;
      exp_d     = seed;
      thr_d     = throttle;
      issued_d  = '0;
      gap_d     = '0;
      word_d    = '0;
      errc_d    = '0;
      error_d   = 1'b0;
      fe_idx_d  = '0;
      fe_data_d = '0;
      fe_exp_d  = '0;
    end else begin
      // Read issue and inter-read gap.
      vld_d = accept;
      if (accept) begin
        issued_d = issued_q + COUNT_WIDTH'(1);
        gap_d    = thr_q;
      end else if (gap_q != 4'd0) begin
        gap_d = gap_q - 4'd1;
      end

      // Compare stage: the expected sequence always advances, even on a
      // mismatch, so a single corrupted word yields a single error.
      if (vld_q) begin
        word_d = word_q + COUNT_WIDTH'(1);
        exp_d  = exp_q + DATA_WIDTH'(1);
        if (read_data != exp_q) begin
          error_d = 1'b1;
          if (errc_q != {COUNT_WIDTH{1'b1}}) errc_d = errc_q + COUNT_WIDTH'(1);
          if (!error_q) begin
            fe_idx_d  = word_q;
            fe_data_d = read_data;
            fe_exp_d  = exp_q;
          end
        end
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge read_clk or posedge read_rst) begin
    if (read_rst) begin
      num_q     <= '0;
      exp_q     <= '0;
      thr_q     <= '0;
      issued_q  <= '0;
      gap_q     <= '0;
      vld_q     <= 1'b0;
      word_q    <= '0;
      errc_q    <= '0;
      error_q   <= 1'b0;
      fe_idx_q  <= '0;
      fe_data_q <= '0;
      fe_exp_q  <= '0;
    end else begin
      num_q     <= num_d;
      exp_q     <= exp_d;
      thr_q     <= thr_d;
      issued_q  <= issued_d;
      gap_q     <= gap_d;
      vld_q     <= vld_d;
      word_q    <= word_d;
      errc_q    <= errc_d;
      error_q   <= error_d;
      fe_idx_q  <= fe_idx_d;
      fe_data_q <= fe_data_d;
      fe_exp_q  <= fe_exp_d;
    end
  end

  assign error              = error_q;
  assign error_count        = errc_q;
  assign word_count         = word_q;
  assign first_err_index    = fe_idx_q;
  assign first_err_data     = fe_data_q;
  assign first_err_expected = fe_exp_q;

endmodule

// File: tb/tb_fifo_read_checker.sv
module tb_fifo_read_checker;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          read_clk = 1'b0;
  logic          read_rst, start, p_read_empty, p_read_en, busy, done, error;
  logic [CW-1:0] num_words, error_count, word_count, first_err_index;
  logic [DW-1:0] seed, read_data, first_err_data, first_err_expected;
  logic [3:0]    throttle;

  always #5 read_clk = ~read_clk;

  fifo_read_checker #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .read_clk(read_clk), .read_rst(read_rst), .start(start),
    .num_words(num_words), .seed(seed), .throttle(throttle),
    .p_read_empty(p_read_empty), .p_read_en(p_read_en), .read_data(read_data),
    .busy(busy), .done(done), .error(error), .error_count(error_count),
    .word_count(word_count), .first_err_index(first_err_index),
    .first_err_data(first_err_data), .first_err_expected(first_err_expected)
  );

  int total = 0;
  int bad   = 0;

  // FIFO contents and environment knobs
  logic [DW-1:0] fifo[$];
  int stall_pct = 0;
  int junk_pct  = 0;

  // Behavioural model: a run is a count of issued reads and compared words;
  // read spacing is judged from the edge number of the previous accept.
  bit            m_active, m_done, m_err, m_pend;
  int            m_n, m_issued, m_words, m_errc, m_thr, m_last, m_cyc, m_fi;
  logic [DW-1:0] m_exp, m_fd, m_fe;

  int acc_log[$];
  int done_seen, done_edge, start_edge;

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_err = 0; m_pend = 0;
    m_n = 0; m_issued = 0; m_words = 0; m_errc = 0; m_thr = 0; m_last = -1000;
    m_fi = 0; m_exp = '0; m_fd = '0; m_fe = '0;
  endtask

  task automatic model_edge(bit st, bit en, logic [DW-1:0] rd);
    if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (st) begin
        m_n = int'(num_words); m_exp = seed; m_thr = int'(throttle);
        m_issued = 0; m_words = 0; m_errc = 0; m_err = 0; m_pend = 0;
        m_fi = 0; m_fd = '0; m_fe = '0; m_last = -1000;
        if (m_n == 0) m_done = 1; else m_active = 1;
      end
    end else begin
      if (m_pend) begin
        if (rd !== m_exp) begin
          if (!m_err) begin m_fi = m_words; m_fd = rd; m_fe = m_exp; end
          m_err = 1;
          if (m_errc < 65535) m_errc++;
        end
        m_words++;
        m_exp = m_exp + 8'd1;
      end
      m_pend = en;
      if (en) begin m_issued++; m_last = m_cyc; acc_log.push_back(m_cyc); end
      if (m_words == m_n) begin m_active = 0; m_done = 1; end
    end
  endtask

  task automatic check_outputs();
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    chk("error", error, m_err);
    chk("error_count", error_count, m_errc);
    chk("word_count", word_count, m_words);
    chk("first_err_index", first_err_index, m_fi);
    chk("first_err_data", first_err_data, m_fd);
    chk("first_err_expected", first_err_expected, m_fe);
    if (done === 1'b1) begin
      done_seen++;
      if (done_edge < 0) done_edge = m_cyc;
    end
  endtask

  task automatic set_empty();
    p_read_empty = (fifo.size() == 0) ||
                   (stall_pct > 0 && $urandom_range(99) < stall_pct);
  endtask

  // One clock: check read request before the edge, advance the model at the
  // edge, check outputs at the falling edge, then act as the FIFO.
  task automatic step();
    bit            st, en, exp_en;
    logic [DW-1:0] rd;
    #1;
    exp_en = m_active && (m_issued < m_n) && !p_read_empty &&
             (m_cyc - m_last >= m_thr);
    chk("p_read_en", p_read_en, exp_en);
    st = start; en = p_read_en; rd = read_data;
    @(posedge read_clk);
    m_cyc++;
    model_edge(st, exp_en, rd);
    @(negedge read_clk);
    check_outputs();
    start = 1'b0;
    if (en && fifo.size() > 0) read_data = fifo.pop_front();
    else                       read_data = DW'($urandom);
    if (m_active && junk_pct > 0 && $urandom_range(99) < junk_pct) begin
      start = 1'b1; num_words = CW'($urandom); seed = DW'($urandom);
      throttle = 4'($urandom);
    end
    set_empty();
  endtask

  task automatic reset_mid();
    #2 read_rst = 1'b1;
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst p_read_en", p_read_en, 0);
    chk("rst word_count", word_count, 0);
    chk("rst error_count", error_count, 0);
    chk("rst first_err_index", first_err_index, 0);
    chk("rst first_err_data", first_err_data, 0);
    chk("rst first_err_expected", first_err_expected, 0);
    model_reset();
    fifo.delete();
    @(negedge read_clk);
    read_rst = 1'b0; start = 1'b0;
    set_empty();
  endtask

  task automatic run(int n, int sd, int thr, int rst_at);
    int budget;
    num_words = CW'(n); seed = DW'(sd); throttle = 4'(thr); start = 1'b1;
    set_empty();
    acc_log.delete(); done_seen = 0; done_edge = -1;
    step();
    start_edge = m_cyc;
    budget = 3000;
    while ((m_active || m_done) && budget > 0) begin
      if (rst_at >= 0 && m_words == rst_at) begin reset_mid(); break; end
      step();
      budget--;
    end
    chk("run_finished", m_active || m_done, 0);
    step();
    fifo.delete();
    set_empty();
  endtask

  initial begin
    read_rst = 1'b1; start = 1'b0; num_words = '0; seed = '0; throttle = '0;
    p_read_empty = 1'b1; read_data = '0;
    model_reset(); m_cyc = 0;
    @(negedge read_clk); @(negedge read_clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset error", error, 0);
    chk("reset p_read_en", p_read_en, 0);
    chk("reset word_count", word_count, 0);
    read_rst = 1'b0;
    step();

    // 16 back-to-back reads from seed 0x00
    for (int i = 0; i < 16; i++) fifo.push_back(DW'(i));
    run(16, 8'h00, 0, -1);
    chk("t1 word_count", word_count, 16);
    chk("t1 error", error, 0);
    chk("t1 accepts", acc_log.size(), 16);
    chk("t1 first accept", acc_log[0], start_edge + 1);
    chk("t1 last accept", acc_log[15], start_edge + 16);
    chk("t1 done edge", done_edge, start_edge + 17);
    chk("t1 done pulses", done_seen, 1);

    // wrap-around of the expected sequence
    fifo.push_back(8'hFE); fifo.push_back(8'hFF);
    fifo.push_back(8'h00); fifo.push_back(8'h01);
    run(4, 8'hFE, 0, -1);
    chk("t2 error", error, 0);
    chk("t2 model expected end", m_exp, 8'h02);

    // single corrupted word
    fifo.push_back(8'h10); fifo.push_back(8'h11);
    fifo.push_back(8'h55); fifo.push_back(8'h13);
    run(4, 8'h10, 0, -1);
    chk("t3 error", error, 1);
    chk("t3 error_count", error_count, 1);
    chk("t3 first_err_index", first_err_index, 2);
    chk("t3 first_err_data", first_err_data, 8'h55);
    chk("t3 first_err_expected", first_err_expected, 8'h12);

    // throttle=2 without stalls: reads exactly every 3rd cycle
    for (int i = 0; i < 5; i++) fifo.push_back(DW'(8'h30 + i));
    run(5, 8'h30, 2, -1);
    chk("t4 accepts", acc_log.size(), 5);
    for (int i = 1; i < 5; i++) chk("t4 spacing", acc_log[i] - acc_log[i-1], 3);

    // throttle=2 with the empty flag toggling
    stall_pct = 40;
    for (int i = 0; i < 5; i++) fifo.push_back(DW'(8'h60 + i));
    run(5, 8'h60, 2, -1);
    chk("t5 accepts", acc_log.size(), 5);
    chk("t5 error", error, 0);
    stall_pct = 0;

    // zero-length run
    run(0, 8'h00, 0, -1);
    chk("t6 accepts", acc_log.size(), 0);
    chk("t6 done edge", done_edge, start_edge);
    chk("t6 done pulses", done_seen, 1);

    // starts while busy are ignored
    junk_pct = 30;
    for (int i = 0; i < 10; i++) fifo.push_back(DW'(8'h80 + i));
    run(10, 8'h80, 1, -1);
    chk("t7 word_count", word_count, 10);
    chk("t7 error", error, 0);
    junk_pct = 0;

    // reset after 3 of 8 words, then a clean run
    for (int i = 0; i < 8; i++) fifo.push_back(DW'(8'h40 + i));
    run(8, 8'h40, 0, 3);
    for (int i = 0; i < 6; i++) fifo.push_back(DW'(8'hA0 + i));
    run(6, 8'hA0, 0, -1);
    chk("t8 word_count", word_count, 6);
    chk("t8 error", error, 0);

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      int n, sd, thr;
      n  = $urandom_range(0, 40);
      sd = $urandom_range(0, 255);
      thr = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 4);
      stall_pct = $urandom_range(0, 50);
      junk_pct  = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) begin
        logic [DW-1:0] w;
        w = DW'(sd + i);
        if ($urandom_range(99) < 8) w = w ^ DW'($urandom_range(1, 255));
        fifo.push_back(w);
      end
      run(n, sd, thr, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_read_checker.md
# fifo_read_checker

Synthesizable read-domain consumer for the async FIFO: drains a programmed number of words through the FIFO read port, optionally throttled, and checks every word against an incrementing expected sequence. It is the counterpart of the write-side pattern source and sits in the read clock domain of the FIFO test harness, reporting word count, error count and the first mismatch for self-checking regressions.

## Interface
Parameters:
- DATA_WIDTH, 8, width of FIFO read data and of the expected-value counter
- COUNT_WIDTH, 16, width of num_words, word and error counters

Ports:
- read_clk  input  1  read-domain clock; all logic on rising edge
- read_rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a run; ignored while busy
- num_words  input  COUNT_WIDTH  words to consume; latched on accepted start
- seed  input  DATA_WIDTH  first expected value; latched on accepted start
- throttle  input  4  idle cycles inserted after each accepted read; latched on accepted start
- p_read_empty  input  1  FIFO empty flag
- p_read_en  output  1  read request to FIFO
- read_data  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read
- busy  output  1  run in progress
- done  output  1  one-cycle pulse at end of run
- error  output  1  sticky; set on any mismatch, cleared on accepted start
- error_count  output  COUNT_WIDTH  mismatches in current run, saturating
- word_count  output  COUNT_WIDTH  words compared in current run
- first_err_index  output  COUNT_WIDTH  word_count value of first mismatch
- first_err_data / first_err_expected  output  DATA_WIDTH each  received/expected data of first mismatch

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Encoding free.
- IDLE: start=1 -> latch num_words/seed/throttle, clear counters, error and first_err_*; go RUN, or DONE directly if num_words==0.
- RUN: p_read_en = !p_read_empty && gap_cnt==0 && issued<num_words (combinational; never asserted while empty). Accepted read = p_read_en. On accept: issued+1, gap_cnt loaded with throttle. gap_cnt decrements to 0 each cycle otherwise. When issued reaches num_words -> DRAIN.
- Compare stage: one-cycle valid flag set on accepted read; on the following edge read_data is compared to expected; word_count+1, expected+1 (mod 2^DATA_WIDTH, wraps 0xFF->0x00 at default width) regardless of match. No resync on mismatch.
- Mismatch: error=1; error_count+1, saturating at all-ones; if first mismatch of run, capture first_err_index (pre-increment word_count), first_err_data, first_err_expected.
- DRAIN: wait until word_count==num_words -> DONE. p_read_en=0.
- DONE: done=1 for one cycle, busy=0 in this state; -> IDLE. Results hold until next accepted start.
- start while busy (RUN/DRAIN/DONE): ignored, no effect on latched values.
- p_read_empty asserted mid-run: reads stall; gap_cnt keeps counting down; no timeout.

## Timing
- Reset (asynchronous assert, synchronous-effect deassert): state IDLE; p_read_en, busy, done, error = 0; all counters and first_err_* = 0.
- Reset mid-run: immediate return to above values; in-flight compare discarded.
- start sampled at edge 0 -> busy=1 from edge 0; earliest p_read_en in cycle after edge 0.
- Read latency: accept at edge N, compare at edge N+1, word_count visible after N+1.
- throttle=T: minimum spacing between accepted reads is T+1 cycles; T=0 allows one read per cycle.
- Last accept at edge N -> final compare at N+1 -> done high cycle N+1..N+2, busy low from N+1 (DONE state).
- num_words==0: done pulses in cycle after start edge, no reads issued.

## Test plan
- seed=0x00, num_words=16, throttle=0, FIFO preloaded 0x00..0x0F -> 16 back-to-back p_read_en, word_count=16, error=0, done one pulse.
- seed=0xFE, num_words=4, FIFO holds 0xFE,0xFF,0x00,0x01 -> error=0 (wrap-around), expected ends at 0x02.
- Data 0x10,0x11,0x55,0x13 with seed=0x10 -> error=1, error_count=1, first_err_index=2, first_err_data=0x55, first_err_expected=0x12.
- throttle=2, num_words=5, FIFO never empty -> p_read_en high exactly every 3rd cycle, 5 accepts; p_read_empty toggled mid-run -> p_read_en never high while empty.
- num_words=0 -> no p_read_en, done pulses one cycle after start; start asserted during RUN -> ignored.
- read_rst asserted mid-RUN after 3 of 8 words -> all outputs 0 immediately; fresh start afterwards completes normally.
